lfsr_checker: RTL and testbench

Downstream consumer of the 6-bit maximal-length LFSR stream (P(x) = x^6 + x^5 + 1, register indexed [1:6]). Each valid beat is compared against the successor predicted from the previous beat. The block acquires sequence lock, tracks errors with a flywheel predictor and reports lock, error and period status. It sits directly after the LFSR generator, or after any link carrying its state stream, as a built-in self-test monitor.

---
 rtl/lfsr_pkg.sv | 20 ++
 rtl/lfsr_checker.sv | 127 ++++++++++++
 tb/tb_lfsr_checker.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared definitions for the 6-bit LFSR (x^6 + x^5 + 1) generator and checker
package lfsr_pkg;

    localparam int LFSR_W = 6;
    localparam int TAP_A  = 6;
    localparam int TAP_B  = 5;
    localparam logic [1:LFSR_W] SEED = 6'b110101;
    localparam int PERIOD = 63;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } fsm_t;

    // Single successor definition used by both ends of the link.
    function automatic logic [1:LFSR_W] lfsr_next(input logic [1:LFSR_W] s);
        return {s[TAP_A] ^ s[TAP_B], s[1:LFSR_W-1]};
    endfunction

endpackage

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - LFSR stream monitor with lock acquisition, flywheel prediction and error/period status
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 3,
    parameter int ERR_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [1:LFSR_W]   data_in,
    input  logic              err_clr,
    output logic              locked,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_count,
    output logic              wrap_pulse,
    output logic              zero_state
);

    localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(UNLOCK_COUNT + 1);
    localparam int PER_W  = $clog2(PERIOD);

    fsm_t               state;
    logic [1:LFSR_W]    ref_state;
    logic               ref_valid;
    logic [RUN_W-1:0]   run_cnt;
    logic [MISS_W-1:0]  miss_cnt;
    logic [PER_W-1:0]   per_cnt;

    logic [1:LFSR_W]    predicted;
    logic               is_zero;
    logic               match;
    logic               err_inc;

    always_comb begin
        predicted = lfsr_next(ref_state);
        is_zero   = (data_in == '0);
        match     = ref_valid && (data_in == predicted) && !is_zero;
        err_inc   = in_valid && (state == LOCKED) && !match;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HUNT;
            ref_state  <= SEED;
            ref_valid  <= 1'b0;
            run_cnt    <= '0;
            miss_cnt   <= '0;
            per_cnt    <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            wrap_pulse <= 1'b0;
            zero_state <= 1'b0;
        end else begin
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;

            // A clear coinciding with a new error keeps that error visible.
            if (err_clr) begin
                err_count <= err_inc ? ERR_W'(1) : '0;
            end else if (err_inc && (err_count != '1)) begin
                err_count <= err_count + ERR_W'(1);
            end

            if (in_valid) begin
                if (is_zero) begin
                    zero_state <= 1'b1;
                end

                case (state)
                    HUNT: begin
                        ref_state <= data_in;
                        ref_valid <= 1'b1;
                        if (match) begin
                            if (run_cnt == RUN_W'(LOCK_COUNT - 1)) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                run_cnt  <= '0;
                                miss_cnt <= '0;
                                per_cnt  <= '0;
                            end else begin
                                run_cnt <= run_cnt + RUN_W'(1);
                            end
                        end else begin
                            run_cnt <= '0;
                        end
                    end

                    LOCKED: begin
                        // Flywheel: prediction ignores the received beat so a single
                        // corrupted beat costs exactly one error.
                        ref_state <= predicted;
                        if (match) begin
                            miss_cnt <= '0;
                            if (per_cnt == PER_W'(PERIOD - 1)) begin
                                per_cnt    <= '0;
                                wrap_pulse <= 1'b1;
                            end else begin
                                per_cnt <= per_cnt + PER_W'(1);
                            end
                        end else begin
                            err_pulse <= 1'b1;
                            if (miss_cnt == MISS_W'(UNLOCK_COUNT - 1)) begin
                                state     <= HUNT;
                                locked    <= 1'b0;
                                run_cnt   <= '0;
                                miss_cnt  <= '0;
                                ref_state <= data_in;
                            end else begin
                                miss_cnt <= miss_cnt + MISS_W'(1);
                            end
                        end
                    end

                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - scoreboard bench for lfsr_checker against an arithmetic reference model
module tb_lfsr_checker;

    localparam int LOCK_COUNT   = 4;
    localparam int UNLOCK_COUNT = 3;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:6]  data_in  = '0;
    logic        err_clr  = 1'b0;

    logic        locked, err_pulse, wrap_pulse, zero_state;
    logic [15:0] err_count;
    logic        locked_s, err_pulse_s, wrap_pulse_s, zero_state_s;
    logic [3:0]  err_count_s;

    lfsr_checker #(.LOCK_COUNT(LOCK_COUNT), .UNLOCK_COUNT(UNLOCK_COUNT), .ERR_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in), .err_clr(err_clr),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
        .wrap_pulse(wrap_pulse), .zero_state(zero_state)
    );

    lfsr_checker #(.LOCK_COUNT(LOCK_COUNT), .UNLOCK_COUNT(UNLOCK_COUNT), .ERR_W(4)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in), .err_clr(err_clr),
        .locked(locked_s), .err_pulse(err_pulse_s), .err_count(err_count_s),
        .wrap_pulse(wrap_pulse_s), .zero_state(zero_state_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          lk;
        bit          ep;
        bit          wp;
        bit          zs;
        int unsigned ec;
        int unsigned ec4;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   wrap_seen = 0;
    int   cyc = 0;

    // Reference model state, value form: bit 5 is register position 1.
    bit          m_locked, m_have_ref, m_zero;
    int          m_ref, m_run, m_miss, m_per;
    int unsigned m_ec, m_ec4;
    logic [5:0]  cur;

    function automatic int succ(input int v);
        return (v >> 1) | (((v ^ (v >> 1)) & 1) << 5);
    endfunction

    task automatic cmp(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, want);
        end
    endtask

    task automatic drive(input bit r, input bit v, input logic [5:0] d, input bit c);
        exp_t e;
        bit   inc, match;
        int   dv, pred;
        @(negedge clk);
        reset = r; in_valid = v; data_in = d; err_clr = c;
        e.ep = 0; e.wp = 0; inc = 0;
        if (r) begin
            m_locked = 0; m_have_ref = 0; m_zero = 0;
            m_run = 0; m_miss = 0; m_per = 0; m_ec = 0; m_ec4 = 0; m_ref = 0;
        end else begin
            if (v) begin
                dv    = int'(d);
                pred  = succ(m_ref);
                match = m_have_ref && (dv == pred) && (dv != 0);
                if (dv == 0) m_zero = 1;
                if (!m_locked) begin
                    m_ref = dv; m_have_ref = 1;
                    if (match) begin
                        m_run++;
                        if (m_run == LOCK_COUNT) begin
                            m_locked = 1; m_miss = 0; m_per = 0; m_run = 0;
                        end
                    end else m_run = 0;
                end else begin
                    m_ref = pred;
                    if (match) begin
                        m_miss = 0;
                        m_per  = (m_per + 1) % 63;
                        if (m_per == 0) e.wp = 1;
                    end else begin
                        e.ep = 1; inc = 1; m_miss++;
                        if (m_miss == UNLOCK_COUNT) begin
                            m_locked = 0; m_run = 0; m_ref = dv; m_miss = 0;
                        end
                    end
                end
            end
            if (c) begin
                m_ec  = inc ? 1 : 0;
                m_ec4 = inc ? 1 : 0;
            end else if (inc) begin
                if (m_ec < 65535) m_ec++;
                if (m_ec4 < 15) m_ec4++;
            end
        end
        e.lk = m_locked; e.zs = m_zero; e.ec = m_ec; e.ec4 = m_ec4;
        q.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (wrap_pulse) wrap_seen++;
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("locked",       int'(locked),      int'(e.lk));
                cmp("err_pulse",    int'(err_pulse),   int'(e.ep));
                cmp("wrap_pulse",   int'(wrap_pulse),  int'(e.wp));
                cmp("zero_state",   int'(zero_state),  int'(e.zs));
                cmp("err_count",    int'(err_count),   int'(e.ec));
                cmp("sat_err_count", int'(err_count_s), int'(e.ec4));
                cmp("sat_locked",   int'(locked_s),    int'(e.lk));
            end
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic clean(input bit c = 0);
        drive(0, 1, cur, c);
        cur = 6'(succ(int'(cur)));
    endtask

    task automatic corrupt(input logic [5:0] mask, input bit c = 0);
        drive(0, 1, cur ^ mask, c);
        cur = 6'(succ(int'(cur)));
    endtask

    task automatic gap(input bit c = 0);
        drive(0, 0, 6'($urandom), c);
    endtask

    task automatic restart();
        drive(1, 0, 6'd0, 0);
        drive(1, 1, 6'd0, 1);
        cur = 6'b110101;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        fork
            monitor();
        join_none

        // Clean stream from the seed: lock lands on the fifth beat.
        restart();
        settle();
        cmp("reset_locked", int'(locked), 0);
        cmp("reset_err_count", int'(err_count), 0);
        repeat (4) clean();
        settle();
        cmp("t1_not_locked_beat4", int'(locked), 0);
        clean();
        settle();
        cmp("t1_locked_beat5", int'(locked), 1);
        repeat (3) clean();

        // One flipped beat gives a single error and the next clean beat matches.
        corrupt(6'b100000);
        settle();
        cmp("t2_err_count", int'(err_count), 1);
        cmp("t2_locked", int'(locked), 1);
        repeat (4) clean();

        // Clear, then three consecutive corruptions unlock; reacquire on the fifth clean beat.
        gap(1);
        repeat (3) corrupt(6'b100000);
        settle();
        cmp("t3_err_count", int'(err_count), 3);
        cmp("t3_unlocked", int'(locked), 0);
        repeat (4) clean();
        settle();
        cmp("t3_not_relocked", int'(locked), 0);
        clean();
        settle();
        cmp("t3_relocked", int'(locked), 1);

        // 126 matched beats with random gaps yield two period wraps.
        restart();
        repeat (5) clean();
        settle();
        w0 = wrap_seen;
        repeat (126) begin
            repeat ($urandom_range(0, 2)) gap();
            clean();
        end
        settle();
        cmp("t4_wrap_total", wrap_seen - w0, 2);
        cmp("t4_locked", int'(locked), 1);

        // Lockup state is always a mismatch and sets the sticky flag.
        restart();
        repeat (8) drive(0, 1, 6'd0, 0);
        repeat (3) gap();
        settle();
        cmp("t5_zero_state", int'(zero_state), 1);
        cmp("t5_locked", int'(locked), 0);
        cmp("t5_err_count", int'(err_count), 0);

        // Interleaved errors hold lock; narrow counter saturates; clear with error gives one.
        restart();
        repeat (5) clean();
        repeat (20) begin
            corrupt(6'(1 << $urandom_range(0, 5)));
            clean();
        end
        settle();
        cmp("t6_sat", int'(err_count_s), 15);
        cmp("t6_wide", int'(err_count), 20);
        cmp("t6_locked", int'(locked_s), 1);
        corrupt(6'b000001, 1);
        settle();
        cmp("t6_clr_with_err", int'(err_count_s), 1);

        // Randomised traffic including lockup beats, clears and mid-stream reset.
        restart();
        repeat (600) begin
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 1) restart();
            else if (sel < 16) gap($urandom_range(0, 9) == 0);
            else if (sel < 20) drive(0, 1, 6'd0, 0);
            else if (sel < 30) corrupt(6'($urandom_range(1, 63)), $urandom_range(0, 9) == 0);
            else clean($urandom_range(0, 19) == 0);
        end

        repeat (3) @(posedge clk);
        #2;
        cmp("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
